uart_frame_receiver: RTL
========================

# uart_frame_receiver

Receive side of the 115200-baud UART frame link. Deserialises 8N1+ bytes from `rx_i`, hunts for the 0xBAFD header, and assembles each 11-byte frame into an 88-bit word that matches the transmitter's `din_i` layout. It sits between the board RX pin and the adder datapath, and reports completed frames and line errors with single-cycle pulses.

## Interface
- `clkfreq`, 100000000: system clock frequency in Hz.
- `baudrate`, 115200: line bit rate.
- `timeout_bits`, 20: maximum idle gap between payload bytes, in bit times, before the frame is aborted.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_i` input 1: asynchronous serial line; idles high.
- `dout_o` output 88: last complete frame. [87:80] is the first byte on the wire (0xBA), [7:0] is the last.
- `frame_valid_o` output 1: one-cycle pulse when `dout_o` has been updated.
- `frame_err_o` output 1: one-cycle pulse when a frame is aborted.
- `byte_o` output 8: last received byte.
- `byte_valid_o` output 1: one-cycle pulse for each good byte.

## Operation
- BIT = clkfreq/baudrate, which is 868 at the default parameters. HALF = BIT/2.
- `rx_i` passes through a 2-FF synchroniser. All decisions use the synchronised value `rxs`.
- Byte FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: when `rxs` was 1 and is now 0, go to START with timer = 0.
  - START: at timer = HALF-1, sample `rxs`. If it is 0, go to DATA with timer = 0 and bit count = 0. If it is 1, this is a false start: return to IDLE with no pulse.
  - DATA: sample at each timer = BIT-1. Bits arrive LSB first and shift into bit [7]. After the 8th sample, go to STOP.
  - STOP: sample at timer = BIT-1.
    - If `rxs` = 1: `byte_o` takes the shift register, `byte_valid_o` pulses, go to IDLE.
    - If `rxs` = 0: framing error. The byte is discarded and an internal `byte_err` pulses. Go to IDLE; IDLE's edge rule means the FSM waits for the line to return high.
  - Only one stop bit is checked, so a transmitter sending 2 stop bits is accepted.
- Frame FSM has three states: HUNT0, HUNT1, PAYLOAD. It advances only on good-byte or `byte_err` events.
  - HUNT0: byte 0xBA goes to HUNT1. Any other byte stays in HUNT0.
  - HUNT1: byte 0xFD goes to PAYLOAD with byte index = 2. Byte 0xBA stays in HUNT1. Any other byte goes to HUNT0.
  - PAYLOAD: each byte shifts into an 88-bit assembly register with left-shift-by-8 semantics, and the index increments.
  - On byte index 10 (the 11th byte): `dout_o` takes {0xBA, 0xFD, 9 payload bytes}, `frame_valid_o` pulses, go to HUNT0.
  - PAYLOAD abort, on either of two causes: a `byte_err`, or the gap timer reaching `timeout_bits`×BIT cycles since the last byte ended. On abort, `frame_err_o` pulses, go to HUNT0, and `dout_o` is unchanged.
  - A `byte_err` in HUNT0 or HUNT1 goes to HUNT0 with no `frame_err_o`.
- `dout_o` holds its value between frames.

## Timing
- Reset values: `dout_o` = 0, `byte_o` = 0, and all pulse outputs = 0. Both FSMs reset to IDLE/HUNT0, with all counters and timers at 0.
- Reset mid-byte or mid-frame discards all partial data and emits no pulse. After reset, a new byte needs a fresh 1→0 edge on `rxs`.
- Start-edge latency: 2 synchroniser cycles plus 1 edge-detect cycle.
- `byte_valid_o` is registered. It asserts in the cycle after the stop-bit sample edge.
- `frame_valid_o` and the new `dout_o` assert in the cycle after the final `byte_valid_o`. A `byte_valid_o` pulse also occurs for the final byte.
- The gap timer runs only in PAYLOAD. It clears on each good byte and when a start bit is confirmed.
- If a timeout and a good byte coincide in the same cycle, the byte wins and the timer clears.
- Back-to-back frames with zero inter-frame gap are received without loss.

## Structure
- Shared package `uart_pkg`:
  - header constants `HDR_HI` = 8'hBA and `HDR_LO` = 8'hFD;
  - `FRAME_BYTES` = 11 and `FRAME_W` = 88;
  - state encodings for both FSMs;
  - a BIT computation function that the transmitter also uses.
- Sub-module `uart_rx_byte` contains the synchroniser, the byte FSM, and the `byte_valid`/`byte_err` outputs.
- The top level contains the frame FSM, the assembly register, and the gap timer.
- Timer width is $clog2(BIT) for the bit timer and $clog2(timeout_bits×BIT) for the gap timer.

## Test plan
- **Single byte:** serialise 0x5A with 2 stop bits → one `byte_valid_o` with `byte_o` = 0x5A, and no frame pulse.
- **Full frame:** send BA FD 01 02 … 09 → `frame_valid_o` pulse one cycle after the 11th `byte_valid_o`, `dout_o` = 88'hBAFD_0102_0304_0506_0708_09.
- **Header hunt:** send 00 BA BA FD + 9 bytes → frame accepted. Send BA 00 FD … → no `frame_valid_o`.
- **Glitch rejection:** a 300-cycle low pulse on `rx_i` → no `byte_valid_o`, and the FSM is back in IDLE. A stop bit forced low on byte 5 of a frame → `frame_err_o` pulse, `dout_o` unchanged.
- **Timeout:** send a header plus 4 bytes, then leave the line idle for 21 bit times → `frame_err_o` pulse. A following valid frame is received correctly.
- **Reset:** assert `rst` for one cycle during payload byte 6 → all outputs 0, no pulses. The next complete frame decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and baud helper for the UART frame link
package uart_pkg;

    localparam logic [7:0] HDR_HI      = 8'hBA;
    localparam logic [7:0] HDR_LO      = 8'hFD;
    localparam int         FRAME_BYTES = 11;
    localparam int         FRAME_W     = FRAME_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        HUNT0,
        HUNT1,
        PAYLOAD
    } frame_state_t;

    // Clock cycles per bit on the line; shared with the transmitter.
    function automatic int bit_cycles(input int clkfreq, input int baudrate);
        return clkfreq / baudrate;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - synchroniser and 8N1 byte deserialiser
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int clkfreq  = 100000000,
    parameter int baudrate = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic       start_ok
);

    localparam int            BIT       = bit_cycles(clkfreq, baudrate);
    localparam int            HALF      = BIT / 2;
    localparam int            TW        = $clog2(BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

    logic            sync1;
    logic            rxs;
    logic            rxs_prev;
    rx_state_t       state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      count, count_n;
    logic [7:0]      shift, shift_n;
    logic [7:0]      data_n;
    logic            valid_n;
    logic            err_n;
    logic            start_ok_n;

    // Two-flop synchroniser plus previous sample for falling-edge detection.
    // Cleared to 0 so a line held low across reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            rxs      <= 1'b0;
            rxs_prev <= 1'b0;
        end else begin
            sync1    <= rx;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

    // Byte FSM state, timers and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            count    <= '0;
            shift    <= '0;
            data     <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            start_ok <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            count    <= count_n;
            shift    <= shift_n;
            data     <= data_n;
            valid    <= valid_n;
            err      <= err_n;
            start_ok <= start_ok_n;
        end
    end

    // Next-state: mid-bit sampling of start, eight data bits LSB first, one stop bit.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        count_n    = count;
        shift_n    = shift;
        data_n     = data;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        start_ok_n = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_n = START;
                    timer_n = '0;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_n = '0;
                    if (!rxs) begin
                        state_n    = DATA;
                        count_n    = '0;
                        start_ok_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_n = '0;
                    shift_n = {rxs, shift[7:1]};
                    count_n = count + 1'b1;
                    if (count == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_n = '0;
                    state_n = IDLE;
                    if (rxs) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_frame_receiver.sv
// rtl/uart_frame_receiver.sv - header hunt, 11-byte frame assembly and gap timeout
module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int clkfreq      = 100000000,
    parameter int baudrate     = 115200,
    parameter int timeout_bits = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_i,
    output logic [FRAME_W-1:0] dout_o,
    output logic               frame_valid_o,
    output logic               frame_err_o,
    output logic [7:0]         byte_o,
    output logic               byte_valid_o
);

    localparam int            BIT      = bit_cycles(clkfreq, baudrate);
    localparam int            GAP      = timeout_bits * BIT;
    localparam int            GW       = $clog2(GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [3:0]    LAST_IDX = 4'(FRAME_BYTES - 1);

    logic               byte_err;
    logic               start_ok;
    frame_state_t       fstate, fstate_n;
    logic [3:0]         idx, idx_n;
    logic [FRAME_W-1:0] asm_r, asm_n;
    logic [FRAME_W-1:0] dout_n;
    logic               fvalid_n;
    logic               ferr_n;
    logic [GW-1:0]      gap, gap_n;

    uart_rx_byte #(
        .clkfreq  (clkfreq),
        .baudrate (baudrate)
    ) u_rx_byte (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx_i),
        .data     (byte_o),
        .valid    (byte_valid_o),
        .err      (byte_err),
        .start_ok (start_ok)
    );

    // Frame FSM state, assembly register, gap timer and frame pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate        <= HUNT0;
            idx           <= '0;
            asm_r         <= '0;
            dout_o        <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            gap           <= '0;
        end else begin
            fstate        <= fstate_n;
            idx           <= idx_n;
            asm_r         <= asm_n;
            dout_o        <= dout_n;
            frame_valid_o <= fvalid_n;
            frame_err_o   <= ferr_n;
            gap           <= gap_n;
        end
    end

    // Next-state: header hunt, payload shifting, completion and abort handling.
    // A good byte is checked before the timeout so a coincident byte wins.
    always_comb begin
        fstate_n = fstate;
        idx_n    = idx;
        asm_n    = asm_r;
        dout_n   = dout_o;
        fvalid_n = 1'b0;
        ferr_n   = 1'b0;
        gap_n    = '0;
        case (fstate)
            HUNT0: begin
                if (byte_valid_o && byte_o == HDR_HI) begin
                    fstate_n = HUNT1;
                end
            end
            HUNT1: begin
                if (byte_err) begin
                    fstate_n = HUNT0;
                end else if (byte_valid_o) begin
                    if (byte_o == HDR_LO) begin
                        fstate_n = PAYLOAD;
                        idx_n    = 4'd2;
                        asm_n    = {{(FRAME_W-16){1'b0}}, HDR_HI, HDR_LO};
                    end else if (byte_o != HDR_HI) begin
                        fstate_n = HUNT0;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_valid_o) begin
                    asm_n = {asm_r[FRAME_W-9:0], byte_o};
                    idx_n = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        dout_n   = {asm_r[FRAME_W-9:0], byte_o};
                        fvalid_n = 1'b1;
                        fstate_n = HUNT0;
                    end
                end else if (byte_err || gap == GAP_LAST) begin
                    ferr_n   = 1'b1;
                    fstate_n = HUNT0;
                end else if (!start_ok) begin
                    gap_n = gap + 1'b1;
                end
            end
            default: fstate_n = HUNT0;
        endcase
    end

endmodule
